// File: rtl/ctu_nstep_pkg.sv
// ctu_nstep_pkg: shared states, data-register layout and domain encodings for the NSTEP controller
package ctu_nstep_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam int CNT_W = 4;
  localparam int DOM_W = 3;
  localparam int SR_W = CNT_W + DOM_W + 1;
  localparam int GO_BIT = SR_W - 1;
  localparam int DOM_LSB = CNT_W;
  localparam int CNT_LSB = 0;
  localparam logic [DOM_W-1:0] DOM_CMP = 3'b001;
  localparam logic [DOM_W-1:0] DOM_DRAM = 3'b010;
  localparam logic [DOM_W-1:0] DOM_JBUS = 3'b100;
endpackage

// File: rtl/ctu_jtag_dr_shreg.sv
// ctu_jtag_dr_shreg: TAP data register with capture/shift and gated serial output
module ctu_jtag_dr_shreg
  import ctu_nstep_pkg::*;
#(
  parameter int W = SR_W
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         en,
  input  logic         capture,
  input  logic         shift,
  input  logic         tdi,
  input  logic [W-1:0] cap,
  output logic [W-1:0] sr,
  output logic         tdo
);
  always_ff @(posedge clk) begin
    if (!rst_l) sr <= '0;
    else if (en && capture) sr <= cap;
    else if (en && shift) sr <= {tdi, sr[W-1:1]};
  end
  assign tdo = en & sr[0];
endmodule

// File: rtl/ctu_jtag_nstep_ctl.sv
// ctu_jtag_nstep_ctl: TCK-domain NSTEP controller launching one stretched N-step request per update
module ctu_jtag_nstep_ctl
  import ctu_nstep_pkg::*;
#(
  parameter int VLD_HOLD = 16,
  parameter int GAP_CYC = 8,
  parameter int CNT_W = ctu_nstep_pkg::CNT_W,
  parameter int DOM_W = ctu_nstep_pkg::DOM_W
) (
  input  logic             clk,
  input  logic             io_pwron_rst_l,
  input  logic             instr_nstep,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  output logic             nstep_tdo,
  output logic [CNT_W-1:0] jtag_nstep_count,
  output logic [DOM_W-1:0] jtag_nstep_domain,
  output logic             jtag_nstep_vld,
  output logic             nstep_busy,
  output logic             nstep_ovfl
);
  localparam int SW = CNT_W + DOM_W + 1;
  localparam int MX = VLD_HOLD > GAP_CYC ? VLD_HOLD : GAP_CYC;
  localparam int CW = $clog2(MX + 1);
  logic [SW-1:0] sr;
  state_t state, state_nx;
  logic [CW-1:0] ctr, ctr_nx;
  logic upd, go, req, acc;
  ctu_jtag_dr_shreg #(.W(SW)) u_shreg (
    .clk(clk), .rst_l(io_pwron_rst_l), .en(instr_nstep), .capture(capture_dr),
    .shift(shift_dr), .tdi(tdi), .cap({nstep_busy, jtag_nstep_domain, jtag_nstep_count}),
    .sr(sr), .tdo(nstep_tdo)
  );
  // update only counts when neither higher-priority strobe is active
  assign upd = instr_nstep & update_dr & ~capture_dr & ~shift_dr;
  assign go = sr[SW-1];
  assign req = upd & go & (|sr[CNT_W +: DOM_W]);
  assign acc = req & (state == IDLE);
  always_comb begin
    state_nx = state;
    ctr_nx = ctr;
    case (state)
      IDLE: if (acc) begin
        state_nx = HOLD;
        ctr_nx = CW'(VLD_HOLD - 1);
      end
      HOLD: if (ctr == '0) begin
        state_nx = GAP_CYC == 0 ? IDLE : GAP;
        ctr_nx = GAP_CYC == 0 ? '0 : CW'(GAP_CYC - 1);
      end else ctr_nx = ctr - 1'b1;
      GAP: if (ctr == '0) state_nx = IDLE;
           else ctr_nx = ctr - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!io_pwron_rst_l) begin
      state <= IDLE;
      ctr <= '0;
      jtag_nstep_count <= '0;
      jtag_nstep_domain <= '0;
      jtag_nstep_vld <= 1'b0;
      nstep_busy <= 1'b0;
      nstep_ovfl <= 1'b0;
    end else begin
      state <= state_nx;
      ctr <= ctr_nx;
      jtag_nstep_vld <= state_nx == HOLD;
      nstep_busy <= state_nx != IDLE;
      if (acc) begin
        jtag_nstep_count <= sr[0 +: CNT_W];
        jtag_nstep_domain <= sr[CNT_W +: DOM_W];
      end
      if (upd && !go) nstep_ovfl <= 1'b0;
      else if (req && state != IDLE) nstep_ovfl <= 1'b1;
    end
  end
endmodule
